// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan display: glyphs, segment bit positions,
// conversion FSM states and a BCD sizing helper.
package seg7_pkg;

  // Conversion FSM states.
  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StCommit
  } conv_state_e;

  // Cathode bit positions: a..g then decimal point.
  localparam int unsigned SegA  = 0;
  localparam int unsigned SegB  = 1;
  localparam int unsigned SegC  = 2;
  localparam int unsigned SegD  = 3;
  localparam int unsigned SegE  = 4;
  localparam int unsigned SegF  = 5;
  localparam int unsigned SegG  = 6;
  localparam int unsigned SegDp = 7;

  // Glyphs as active-high segment masks, bit 0 = a .. bit 6 = g.
  localparam logic [6:0] Glyph0     = 7'h3F;
  localparam logic [6:0] Glyph1     = 7'h06;
  localparam logic [6:0] Glyph2     = 7'h5B;
  localparam logic [6:0] Glyph3     = 7'h4F;
  localparam logic [6:0] Glyph4     = 7'h66;
  localparam logic [6:0] Glyph5     = 7'h6D;
  localparam logic [6:0] Glyph6     = 7'h7D;
  localparam logic [6:0] Glyph7     = 7'h07;
  localparam logic [6:0] Glyph8     = 7'h7F;
  localparam logic [6:0] Glyph9     = 7'h6F;
  localparam logic [6:0] GlyphDash  = 7'h40;
  localparam logic [6:0] GlyphBlank = 7'h00;

  // Active-high glyph for one BCD digit; non-decimal codes render blank.
  function automatic logic [6:0] glyph_of(input logic [3:0] digit);
    unique case (digit)
      4'd0:    return Glyph0;
      4'd1:    return Glyph1;
      4'd2:    return Glyph2;
      4'd3:    return Glyph3;
      4'd4:    return Glyph4;
      4'd5:    return Glyph5;
      4'd6:    return Glyph6;
      4'd7:    return Glyph7;
      4'd8:    return Glyph8;
      4'd9:    return Glyph9;
      default: return GlyphBlank;
    endcase
  endfunction

  // Decimal digits needed to hold any w-bit unsigned value (floor(w*log10(2)) + 1).
  function automatic int unsigned bcd_digits(input int unsigned w);
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Iterative double-dabble converter: one add-3/shift step per cycle, VALUE_W steps.
// done_o is high during the final step; bcd_o/overflow_o hold the result from the
// following cycle until the next start_i.
module seg7_bin2bcd
  import seg7_pkg::*;
#(
  parameter int unsigned VALUE_W    = 14,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic                    clock,
  input  logic                    resetb,
  input  logic                    start_i,
  input  logic [VALUE_W-1:0]      value_i,
  output logic                    done_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    overflow_o
);

  // Wide enough for any VALUE_W input so out-of-range values are seen, not truncated.
  localparam int unsigned CalcDigits = bcd_digits(VALUE_W);
  localparam int unsigned TotDigits  = (CalcDigits > NUM_DIGITS) ? CalcDigits : NUM_DIGITS;
  localparam int unsigned BcdW       = 4 * TotDigits;
  localparam int unsigned CntW       = $clog2(VALUE_W + 1);

  logic [VALUE_W-1:0] bin_q;
  logic [BcdW-1:0]    bcd_q;
  logic [BcdW-1:0]    bcd_adj;
  logic [CntW-1:0]    cnt_q;

  // Add 3 to every BCD digit that is 5 or more ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(TotDigits); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Load on start, then shift the combined BCD/binary register once per cycle.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start_i) begin
      bin_q <= value_i;
      bcd_q <= '0;
      cnt_q <= CntW'(VALUE_W);
    end else if (cnt_q != '0) begin
      {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
      cnt_q          <= cnt_q - 1'b1;
    end
  end

  assign done_o     = (cnt_q == CntW'(1));
  assign bcd_o      = bcd_q[4*NUM_DIGITS-1:0];
  assign overflow_o = |(bcd_q >> (4 * NUM_DIGITS));

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed 7-segment display driver: accepts a binary value, converts it to BCD,
// and scans the digits with registered anode/cathode outputs.
// Optional feature macro: SEG7_DEADTIME_EN blanks all anodes for the last two prescaler
// cycles of every digit slot (needs REFRESH_DIV >= 4).
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned VALUE_W        = 14,
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic [VALUE_W-1:0]    value_i,
  input  logic                  value_valid_i,
  output logic                  value_ready_o,
  input  logic [NUM_DIGITS-1:0] dp_mask_i,
  input  logic                  blank_lz_i,
  output logic [NUM_DIGITS-1:0] anode_o,
  output logic [7:0]            cathode_o,
  output logic                  busy_o,
  output logic                  overflow_o
);

  localparam int unsigned PrescW = $clog2(REFRESH_DIV);
  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]  SegOff = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  conv_state_e             state_q;
  logic [4*NUM_DIGITS-1:0] disp_q;
  logic                    ovf_q;
  logic [PrescW-1:0]       presc_q;
  logic [IdxW-1:0]         idx_q;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [7:0]              cathode_q, cathode_d;

  logic                    conv_start;
  logic                    conv_done;
  logic [4*NUM_DIGITS-1:0] conv_bcd;
  logic                    conv_ovf;
  logic                    last_tick;
  logic [3:0]              cur_digit;
  logic                    upper_zero;
  logic [7:0]              seg_on;

  assign conv_start = value_valid_i && (state_q == StIdle);

  seg7_bin2bcd #(
    .VALUE_W    (VALUE_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clock      (clock),
    .resetb     (resetb),
    .start_i    (conv_start),
    .value_i    (value_i),
    .done_o     (conv_done),
    .bcd_o      (conv_bcd),
    .overflow_o (conv_ovf)
  );

  // Conversion FSM; the display register and overflow flag load when leaving COMMIT.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q <= StIdle;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (value_valid_i) state_q <= StConv;
        end
        StConv: begin
          if (conv_done) state_q <= StCommit;
        end
        StCommit: begin
          disp_q  <= conv_bcd;
          ovf_q   <= conv_ovf;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign value_ready_o = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign overflow_o    = ovf_q;

  assign last_tick = (presc_q == PrescW'(REFRESH_DIV - 1));

  // Slot prescaler and digit index.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (last_tick) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // Next anode/cathode pattern from the current index and display register.
  always_comb begin
    cur_digit  = 4'(disp_q >> {idx_q, 2'b00});
    // All digits from this one upward are zero: candidate for leading-zero blanking.
    upper_zero = ((disp_q >> {idx_q, 2'b00}) == '0);

    seg_on             = '0;
    seg_on[SegDp]      = dp_mask_i[idx_q];
    seg_on[SegG:SegA]  = glyph_of(cur_digit);
    if (ovf_q) begin
      seg_on[SegG:SegA] = GlyphDash;
    end else if (blank_lz_i && (idx_q != '0) && upper_zero) begin
      seg_on[SegG:SegA] = GlyphBlank;
    end
    cathode_d = SEG_ACTIVE_LOW ? ~seg_on : seg_on;

    anode_d        = '0;
    anode_d[idx_q] = 1'b1;
`ifdef SEG7_DEADTIME_EN
    // Output lags by one cycle, so this blanks the last two visible cycles of the slot.
    if (presc_q >= PrescW'(REFRESH_DIV - 2)) anode_d = '0;
`endif
  end

  // Registered display outputs.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      anode_q   <= '0;
      cathode_q <= SegOff;
    end else begin
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign anode_o   = anode_q;
  assign cathode_o = cathode_q;

endmodule
